// File: rtl/event_input_queue.sv
// event_input_queue: timestamps raw input events and buffers them in a show-ahead FIFO for the LLC
// Optional: define QUEUE_DROP_COUNT_EN to add the saturating q_drop_cnt output.
// Ports:
//   clk, rst (sync, active-low), en (0 freezes all state)
//   input_x/new_input  : incoming event value and strobe
//   pop_req            : LLC consumes the head entry
//   q_x/q_ts/q_valid   : head entry (registered, show-ahead)
//   q_full/q_count     : occupancy status
//   q_push_valid/q_pop_valid/q_overflow : one-cycle registered pulses for the previous cycle
//   q_drop_cnt         : saturating count of dropped events (QUEUE_DROP_COUNT_EN only)
module event_input_queue #(
    parameter int DATA_W = 64,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [DATA_W-1:0]          input_x,
    input  logic                       new_input,
    input  logic                       pop_req,
    output logic [DATA_W-1:0]          q_x,
    output logic [TS_W-1:0]            q_ts,
    output logic                       q_valid,
    output logic                       q_full,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       q_push_valid,
    output logic                       q_pop_valid,
    output logic                       q_overflow
`ifdef QUEUE_DROP_COUNT_EN
    ,
    output logic [15:0]                q_drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + TS_W;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            push_v_q, pop_v_q, ovf_q;
    logic            push, pop, drop;

    always_comb begin
        pop  = en & pop_req & (count_q != '0);
        // A pop in the same cycle frees a slot, so a full queue still accepts the push.
        push = en & new_input & ((count_q < CW'(DEPTH)) | pop);
        drop = en & new_input & (count_q == CW'(DEPTH)) & ~pop;
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {input_x, ts_q};
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        ts_d     = ts_q + TS_W'(en);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ts_q     <= '0;
            push_v_q <= 1'b0;
            pop_v_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ts_q     <= ts_d;
            push_v_q <= push;
            pop_v_q  <= pop;
            ovf_q    <= drop;
        end
    end

    assign {q_x, q_ts}  = mem_q[rd_ptr_q];
    assign q_valid      = count_q != '0;
    assign q_full       = count_q == CW'(DEPTH);
    assign q_count      = count_q;
    assign q_push_valid = push_v_q;
    assign q_pop_valid  = pop_v_q;
    assign q_overflow   = ovf_q;

`ifdef QUEUE_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) drop_cnt_q <= '0;
        else      drop_cnt_q <= drop_cnt_d;
    end

    assign q_drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_event_input_queue.sv
// tb_event_input_queue: directed self-checking bench for event_input_queue (DEPTH=4)
module tb_event_input_queue;
    logic        clk = 1'b0;
    logic        rst, en, new_input, pop_req;
    logic [63:0] input_x;
    logic [63:0] q_x;
    logic [31:0] q_ts;
    logic        q_valid, q_full, q_push_valid, q_pop_valid, q_overflow;
    logic [2:0]  q_count;
`ifdef QUEUE_DROP_COUNT_EN
    logic [15:0] q_drop_cnt;
`endif
    int n_chk = 0;
    int n_fail = 0;

    event_input_queue dut (
        .clk(clk), .rst(rst), .en(en), .input_x(input_x), .new_input(new_input),
        .pop_req(pop_req), .q_x(q_x), .q_ts(q_ts), .q_valid(q_valid), .q_full(q_full),
        .q_count(q_count), .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid),
        .q_overflow(q_overflow)
`ifdef QUEUE_DROP_COUNT_EN
        , .q_drop_cnt(q_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_strobes(input string tag, input logic pv, input logic ppv, input logic ov);
        chk({tag, ".push_valid"}, 64'(q_push_valid), 64'(pv));
        chk({tag, ".pop_valid"},  64'(q_pop_valid),  64'(ppv));
        chk({tag, ".overflow"},   64'(q_overflow),   64'(ov));
    endtask

    initial begin
        logic [63:0] exp_x [4];
        logic [31:0] exp_ts [4];
        int ovf_n;
        rst = 1'b0; en = 1'b1; new_input = 1'b0; pop_req = 1'b0; input_x = '0;
        tick();
        tick();
        chk("rst.valid", 64'(q_valid), 64'd0);
        chk("rst.count", 64'(q_count), 64'd0);
        chk("rst.full",  64'(q_full),  64'd0);
        chk("rst.ts",    64'(q_ts),    64'd0);
        chk("rst.x",     q_x,          64'd0);
        chk_strobes("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        // ts_cnt is 0 after the reset edge; five idle edges bring it to 5.
        repeat (5) tick();
        new_input = 1'b1; input_x = 64'd1;
        tick();
        chk("single.valid", 64'(q_valid), 64'd1);
        chk("single.x",     q_x,          64'd1);
        chk("single.ts",    64'(q_ts),    64'd5);
        chk("single.count", 64'(q_count), 64'd1);
        chk_strobes("single", 1'b1, 1'b0, 1'b0);
        new_input = 1'b0; pop_req = 1'b1;
        tick();
        chk("pop.valid", 64'(q_valid), 64'd0);
        chk("pop.count", 64'(q_count), 64'd0);
        chk_strobes("pop", 1'b0, 1'b1, 1'b0);
        tick();
        chk("empty_pop.count", 64'(q_count), 64'd0);
        chk_strobes("empty_pop", 1'b0, 1'b0, 1'b0);
        pop_req = 1'b0;
        // ts_cnt = 8 here: burst entries get timestamps 8,9,10,11.
        ovf_n = 0;
        for (int i = 1; i <= 8; i++) begin
            new_input = 1'b1; input_x = 64'(i);
            tick();
            chk($sformatf("burst%0d.overflow", i), 64'(q_overflow), 64'(i > 4));
            if (q_overflow) ovf_n++;
        end
        new_input = 1'b0;
        tick();
        chk("burst.ovf_pulses", 64'(ovf_n), 64'd4);
        chk("burst.overflow_end", 64'(q_overflow), 64'd0);
        chk("burst.full",  64'(q_full),  64'd1);
        chk("burst.count", 64'(q_count), 64'd4);
        chk("burst.x",     q_x,          64'd1);
        chk("burst.ts",    64'(q_ts),    64'd8);
`ifdef QUEUE_DROP_COUNT_EN
        chk("burst.drop_cnt", 64'(q_drop_cnt), 64'd4);
`endif
        // ts_cnt = 17: simultaneous push and pop on a full queue.
        new_input = 1'b1; input_x = 64'd9; pop_req = 1'b1;
        tick();
        chk("fullpp.x",     q_x,          64'd2);
        chk("fullpp.full",  64'(q_full),  64'd1);
        chk("fullpp.count", 64'(q_count), 64'd4);
        chk_strobes("fullpp", 1'b1, 1'b1, 1'b0);
        new_input = 1'b0;
        exp_x  = '{64'd2, 64'd3, 64'd4, 64'd9};
        exp_ts = '{32'd9, 32'd10, 32'd11, 32'd17};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d.x", k),  q_x,        exp_x[k]);
            chk($sformatf("drain%0d.ts", k), 64'(q_ts),  64'(exp_ts[k]));
            tick();
        end
        chk("drain.count", 64'(q_count), 64'd0);
        pop_req = 1'b0;
        // ts_cnt = 22: two entries before the freeze.
        new_input = 1'b1; input_x = 64'd100;
        tick();
        input_x = 64'hFFFF_FFFF_FFFF_FFFB;
        tick();
        new_input = 1'b0;
        chk("prefreeze.count", 64'(q_count), 64'd2);
        en = 1'b0; new_input = 1'b1; pop_req = 1'b1; input_x = 64'd7;
        repeat (5) tick();
        chk("freeze.count", 64'(q_count), 64'd2);
        chk("freeze.ts",    64'(q_ts),    64'd22);
        chk("freeze.x",     q_x,          64'd100);
        chk_strobes("freeze", 1'b0, 1'b0, 1'b0);
        en = 1'b1; pop_req = 1'b0; input_x = 64'd55;
        tick();
        new_input = 1'b0;
        // The third entry carries ts 24, proving ts_cnt held during the freeze.
        chk("postfreeze.count", 64'(q_count), 64'd3);
        pop_req = 1'b1;
        tick();
        tick();
        pop_req = 1'b0;
        chk("postfreeze.ts", 64'(q_ts), 64'd24);
        chk("postfreeze.x",  q_x,       64'd55);
        new_input = 1'b1; input_x = 64'd11;
        tick();
        input_x = 64'd12;
        tick();
        new_input = 1'b0;
        chk("premid.count", 64'(q_count), 64'd3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst.count", 64'(q_count), 64'd0);
        chk("midrst.valid", 64'(q_valid), 64'd0);
        chk("midrst.x",     q_x,          64'd0);
        pop_req = 1'b1; new_input = 1'b1; input_x = 64'hFFFF_FFFF_FFFF_FFFD;
        tick();
        pop_req = 1'b0; new_input = 1'b0;
        chk("midrst.count1", 64'(q_count), 64'd1);
        chk("midrst.ts",     64'(q_ts),    64'd0);
        chk("midrst.x_neg",  q_x,          64'hFFFF_FFFF_FFFF_FFFD);
        chk_strobes("midrst", 1'b1, 1'b0, 1'b0);
`ifdef QUEUE_DROP_COUNT_EN
        chk("midrst.drop_cnt", 64'(q_drop_cnt), 64'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
